// File: rtl/msfp_pkg.sv
// rtl/msfp_pkg.sv - shared fp16 / msfp8 format constants
package msfp_pkg;
  localparam int FP16_W      = 16;
  localparam int MSFP8_W     = 8;
  localparam int EXP_W       = 5;
  localparam int EXP_BIAS    = 15;
  localparam int FP16_MAN_W  = 10;
  localparam int MSFP8_MAN_W = 2;

  localparam logic [6:0] MSFP8_MAX_FIN = 7'h7B;
  localparam logic [6:0] MSFP8_INF     = 7'h7C;
  localparam logic [6:0] MSFP8_QNAN    = 7'h7E;
endpackage

// File: rtl/fp16_to_msfp8_lane.sv
// rtl/fp16_to_msfp8_lane.sv - combinational fp16 to msfp8 lane with round-to-nearest-even
module fp16_to_msfp8_lane
  import msfp_pkg::*;
#(
  parameter int SAT = 1
) (
  input  logic [FP16_W-1:0]  fp16_i,
  output logic [MSFP8_W-1:0] msfp8_o,
  output logic               ovf_o,
  output logic               unf_o,
  output logic               inexact_o
);

  logic                  sgn;
  logic [EXP_W-1:0]      exp_f;
  logic [FP16_MAN_W-1:0] man;
  logic                  guard;
  logic                  sticky;
  logic                  round_up;
  logic [6:0]            rnd;

  assign sgn      = fp16_i[15];
  assign exp_f    = fp16_i[14:10];
  assign man      = fp16_i[9:0];
  assign guard    = man[7];
  assign sticky   = |man[6:0];
  assign round_up = guard && (sticky || man[8]);
  // Carry out of the mantissa bits lands in the exponent, which also promotes denormals.
  assign rnd      = {exp_f, man[9:8]} + {6'd0, round_up};

  always_comb begin
    msfp8_o   = {sgn, rnd};
    ovf_o     = 1'b0;
    inexact_o = guard || sticky;
    if (exp_f == 5'h1F) begin
      inexact_o = 1'b0;
      msfp8_o   = {sgn, (man != '0) ? MSFP8_QNAN : MSFP8_INF};
    end else if (rnd[6:2] == 5'h1F) begin
      ovf_o   = 1'b1;
      msfp8_o = {sgn, (SAT != 0) ? MSFP8_MAX_FIN : MSFP8_INF};
    end
  end

  assign unf_o = ((exp_f != '0) || (man != '0)) && (msfp8_o[6:0] == 7'd0);

endmodule

// File: rtl/fp16_to_msfp8_stream.sv
// rtl/fp16_to_msfp8_stream.sv - 2-stage valid/ready fp16 to msfp8 encoder with exception counters
module fp16_to_msfp8_stream
  import msfp_pkg::*;
#(
  parameter int LANES = 4,
  parameter int SAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FP16_W*LANES-1:0]    in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MSFP8_W*LANES-1:0]   out_data,
  output logic [LANES-1:0]           out_ovf,
  output logic [LANES-1:0]           out_unf,
  output logic [LANES-1:0]           out_inexact,
  input  logic                       clr_counts,
  output logic [CNT_W-1:0]           ovf_count,
  output logic [CNT_W-1:0]           unf_count
);

  localparam int POP_W = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + POP_W;
  localparam logic [SUM_W-1:0] CNT_MAX = {{POP_W{1'b0}}, {CNT_W{1'b1}}};

  logic                         s1_valid_q;
  logic [FP16_W*LANES-1:0]      s1_data_q;
  logic                         s2_valid_q;
  logic [MSFP8_W*LANES-1:0]     s2_data_q;
  logic [LANES-1:0]             s2_ovf_q;
  logic [LANES-1:0]             s2_unf_q;
  logic [LANES-1:0]             s2_inexact_q;
  logic [CNT_W-1:0]             ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0]             unf_cnt_q, unf_cnt_d;

  logic                         s1_adv, s2_adv, out_hs;
  logic [MSFP8_W*LANES-1:0]     lane_data;
  logic [LANES-1:0]             lane_ovf, lane_unf, lane_inexact;
  logic [POP_W-1:0]             ovf_pop, unf_pop;
  logic [SUM_W-1:0]             ovf_sum, unf_sum;

  // out_ready reaches in_ready combinationally so a full pipe still streams at one beat per cycle.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_hs   = s2_valid_q && out_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp16_to_msfp8_lane #(.SAT(SAT)) u_lane (
      .fp16_i    (s1_data_q[FP16_W*g +: FP16_W]),
      .msfp8_o   (lane_data[MSFP8_W*g +: MSFP8_W]),
      .ovf_o     (lane_ovf[g]),
      .unf_o     (lane_unf[g]),
      .inexact_o (lane_inexact[g])
    );
  end

  always_comb begin
    ovf_pop = '0;
    unf_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      ovf_pop = ovf_pop + POP_W'(s2_ovf_q[i]);
      unf_pop = unf_pop + POP_W'(s2_unf_q[i]);
    end
    ovf_sum   = {{POP_W{1'b0}}, ovf_cnt_q} + SUM_W'(ovf_pop);
    unf_sum   = {{POP_W{1'b0}}, unf_cnt_q} + SUM_W'(unf_pop);
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (clr_counts) begin
      ovf_cnt_d = '0;
      unf_cnt_d = '0;
    end else if (out_hs) begin
      ovf_cnt_d = (ovf_sum > CNT_MAX) ? {CNT_W{1'b1}} : ovf_sum[CNT_W-1:0];
      unf_cnt_d = (unf_sum > CNT_MAX) ? {CNT_W{1'b1}} : unf_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_ovf_q     <= '0;
      s2_unf_q     <= '0;
      s2_inexact_q <= '0;
      ovf_cnt_q    <= '0;
      unf_cnt_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_data_q <= in_data;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q    <= lane_data;
          s2_ovf_q     <= lane_ovf;
          s2_unf_q     <= lane_unf;
          s2_inexact_q <= lane_inexact;
        end
      end
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_data    = s2_data_q;
  assign out_ovf     = s2_ovf_q;
  assign out_unf     = s2_unf_q;
  assign out_inexact = s2_inexact_q;
  assign ovf_count   = ovf_cnt_q;
  assign unf_count   = unf_cnt_q;

endmodule

// File: tb/tb_fp16_to_msfp8_stream.sv
// tb/tb_fp16_to_msfp8_stream.sv - self-checking bench for fp16_to_msfp8_stream
module tb_fp16_to_msfp8_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main build: LANES=4, SAT=1, CNT_W=16
  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_clr;
  logic [63:0] m_in_data;
  logic [31:0] m_out_data;
  logic [3:0]  m_ovf, m_unf, m_inx;
  logic [15:0] m_ovf_cnt, m_unf_cnt;

  // SAT=0 build
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_clr;
  logic [63:0] s_in_data;
  logic [31:0] s_out_data;
  logic [3:0]  s_ovf, s_unf, s_inx;
  logic [15:0] s_ovf_cnt, s_unf_cnt;

  // CNT_W=4 build
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_clr;
  logic [63:0] c_in_data;
  logic [31:0] c_out_data;
  logic [3:0]  c_ovf, c_unf, c_inx;
  logic [3:0]  c_ovf_cnt, c_unf_cnt;

  fp16_to_msfp8_stream #(.LANES(4), .SAT(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
    .out_ovf(m_ovf), .out_unf(m_unf), .out_inexact(m_inx),
    .clr_counts(m_clr), .ovf_count(m_ovf_cnt), .unf_count(m_unf_cnt)
  );

  fp16_to_msfp8_stream #(.LANES(4), .SAT(0), .CNT_W(16)) u_sat0 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_ovf(s_ovf), .out_unf(s_unf), .out_inexact(s_inx),
    .clr_counts(s_clr), .ovf_count(s_ovf_cnt), .unf_count(s_unf_cnt)
  );

  fp16_to_msfp8_stream #(.LANES(4), .SAT(1), .CNT_W(4)) u_cnt4 (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_ovf(c_ovf), .out_unf(c_unf), .out_inexact(c_inx),
    .clr_counts(c_clr), .ovf_count(c_ovf_cnt), .unf_count(c_unf_cnt)
  );

  typedef struct {
    logic [63:0] din;
    logic [31:0] dout;
    logic [3:0]  ovf;
    logic [3:0]  unf;
    logic [3:0]  inx;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bp_beat(input int k);
    logic [63:0] r;
    for (int j = 0; j < 4; j++) r[16*j +: 16] = 16'((k*4 + j + 1) << 10);
    return r;
  endfunction

  function automatic logic [31:0] bp_exp(input int k);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = 8'((k*4 + j + 1) << 2);
    return r;
  endfunction

  function automatic int pop4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  initial begin
    int exp_ovf_cnt, exp_unf_cnt, sent, rcv;
    logic in_hs, out_hs, saw_full;

    vecs[0] = '{64'h8000_3D80_3C80_3C00, 32'h803E3C3C, 4'b0000, 4'b0000, 4'b0110};
    vecs[1] = '{64'h0001_FE00_FC00_7BFF, 32'h00FEFC7B, 4'b0001, 4'b1000, 4'b1001};
    vecs[2] = '{64'h0000_03F0_01E0_00E0, 32'h00040201, 4'b0000, 4'b0000, 4'b0111};
    vecs[3] = '{64'h7C00_7E01_3C40_3CC0, 32'h7C7E3C3D, 4'b0000, 4'b0000, 4'b0011};
    vecs[4] = '{64'h8001_BC00_3F80_3E80, 32'h80BC403E, 4'b0000, 4'b1000, 4'b1011};

    m_in_valid = 0; m_in_data = '0; m_out_ready = 1; m_clr = 0;
    s_in_valid = 0; s_in_data = '0; s_out_ready = 1; s_clr = 0;
    c_in_valid = 0; c_in_data = '0; c_out_ready = 1; c_clr = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_out_valid", m_out_valid, 0);
    check("rst_in_ready", m_in_ready, 1);
    check("rst_ovf_count", m_ovf_cnt, 0);
    check("rst_unf_count", m_unf_cnt, 0);
    check("rst_out_data", m_out_data, 0);

    // Table-driven single beats with exact 2-cycle latency
    exp_ovf_cnt = 0;
    exp_unf_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_in_valid = 1;
      m_in_data  = vecs[i].din;
      #1 check($sformatf("v%0d_in_ready", i), m_in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      m_in_valid = 0;
      #1 check($sformatf("v%0d_lat1_valid", i), m_out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_lat2_valid", i), m_out_valid, 1);
      check($sformatf("v%0d_data", i), m_out_data, vecs[i].dout);
      check($sformatf("v%0d_ovf", i), m_ovf, vecs[i].ovf);
      check($sformatf("v%0d_unf", i), m_unf, vecs[i].unf);
      check($sformatf("v%0d_inexact", i), m_inx, vecs[i].inx);
      @(posedge clk);
      @(negedge clk);
      #1;
      exp_ovf_cnt += pop4(vecs[i].ovf);
      exp_unf_cnt += pop4(vecs[i].unf);
      check($sformatf("v%0d_drained", i), m_out_valid, 0);
      check($sformatf("v%0d_ovf_count", i), m_ovf_cnt, 64'(exp_ovf_cnt));
      check($sformatf("v%0d_unf_count", i), m_unf_cnt, 64'(exp_unf_cnt));
    end

    // SAT=0 build: overflow to inf and denormal round-up carries
    @(negedge clk);
    s_in_valid = 1;
    s_in_data  = 64'h03F0_01E0_00E0_7BFF;
    @(posedge clk);
    @(negedge clk);
    s_in_data  = 64'hFBFF_7C00_8000_0000;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 0;
    #1;
    check("sat0_b0_valid", s_out_valid, 1);
    check("sat0_b0_data", s_out_data, 32'h0402017C);
    check("sat0_b0_ovf", s_ovf, 4'b0001);
    check("sat0_b0_unf", s_unf, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("sat0_b1_valid", s_out_valid, 1);
    check("sat0_b1_data", s_out_data, 32'hFC7C8000);
    check("sat0_b1_ovf", s_ovf, 4'b1000);
    @(posedge clk);
    @(negedge clk);
    #1 check("sat0_ovf_count", s_ovf_cnt, 2);

    // CNT_W=4 build: 20 overflowing lanes saturate at 15
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      c_in_valid = 1;
      c_in_data  = {4{16'h7BFF}};
      @(posedge clk);
    end
    @(negedge clk);
    c_in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check("cnt4_saturate", c_ovf_cnt, 15);
    check("cnt4_unf_zero", c_unf_cnt, 0);

    // clr_counts coincident with an overflowing output handshake
    c_in_valid = 1;
    c_in_data  = {4{16'h7BFF}};
    @(posedge clk);
    @(negedge clk);
    c_in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    #1 check("cnt4_clr_beat_valid", c_out_valid, 1);
    c_clr = 1;
    @(posedge clk);
    @(negedge clk);
    c_clr = 0;
    #1 check("cnt4_clr_wins", c_ovf_cnt, 0);
    check("cnt4_clr_drained", c_out_valid, 0);
    c_in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    c_in_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check("cnt4_after_clr", c_ovf_cnt, 4);

    // Backpressure: 6 beats, out_ready low in cycles 3..7
    sent = 0;
    rcv = 0;
    saw_full = 0;
    for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
      @(negedge clk);
      m_out_ready = !(cyc >= 3 && cyc <= 7);
      m_in_valid  = (sent < 6);
      m_in_data   = bp_beat(sent);
      #1;
      check("bp_in_ready", m_in_ready, !((sent - rcv) == 2 && !m_out_ready));
      if ((sent - rcv) == 2 && !m_out_ready && !m_in_ready) saw_full = 1;
      if (m_out_valid) check($sformatf("bp_data%0d", rcv), m_out_data, bp_exp(rcv));
      in_hs  = m_in_valid && m_in_ready;
      out_hs = m_out_valid && m_out_ready;
      @(posedge clk);
      if (in_hs) sent++;
      if (out_hs) rcv++;
    end
    m_in_valid  = 0;
    m_out_ready = 1;
    check("bp_received", rcv, 6);
    check("bp_sent", sent, 6);
    check("bp_saw_full", saw_full, 1);
    repeat (3) begin
      @(negedge clk);
      #1 check("bp_no_dup", m_out_valid, 0);
    end

    // Asynchronous reset with both stages full
    @(negedge clk);
    m_out_ready = 0;
    m_in_valid  = 1;
    m_in_data   = {4{16'h7BFF}};
    @(posedge clk);
    @(negedge clk);
    m_in_data   = {4{16'h0001}};
    @(posedge clk);
    @(negedge clk);
    m_in_valid  = 0;
    #1;
    check("rst_pre_full_in_ready", m_in_ready, 0);
    check("rst_pre_out_valid", m_out_valid, 1);
    check("rst_pre_ovf_count", m_ovf_cnt, 1);
    #2 rst = 1;
    #1;
    check("rst_async_out_valid", m_out_valid, 0);
    check("rst_async_ovf_count", m_ovf_cnt, 0);
    check("rst_async_unf_count", m_unf_cnt, 0);
    @(negedge clk);
    rst = 0;
    m_out_ready = 1;
    #1 check("rst_release_in_ready", m_in_ready, 1);
    repeat (4) begin
      @(negedge clk);
      #1 check("rst_no_stale", m_out_valid, 0);
    end
    check("rst_post_ovf_count", m_ovf_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
